// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider, one quotient bit per clock, with
// valid/ready handshakes on both sides and signed/unsigned operation per request.
module seq_divider #(
   parameter int unsigned WIDTH     = 8,
   parameter bit          SIGNED_EN = 1'b1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_is_signed,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [WIDTH-1:0] o_q,
   output logic [WIDTH-1:0] o_r,
   output logic             o_div_by_zero,
   output logic             o_overflow
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_in_ready;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_dvd;
   logic [WIDTH-1:0] r_div;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_a;
   logic [CW-1:0]    r_cnt;
   logic             r_neg_q;
   logic             r_neg_r;
   logic             r_dz;
   logic             r_ovf;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_r;
   logic             r_dz_o;
   logic             r_ovf_o;

   logic             w_accept;
   logic             w_take;
   logic             w_last;
   logic             w_sgn;
   logic             w_a_neg;
   logic             w_b_neg;
   logic [WIDTH-1:0] w_a_abs;
   logic [WIDTH-1:0] w_b_abs;
   logic [WIDTH-1:0] w_min;
   logic             w_ovf_in;
   logic [WIDTH:0]   w_shift;
   logic             w_ge;
   logic [WIDTH-1:0] w_sub;
   logic [WIDTH-1:0] w_rem_nxt;
   logic [WIDTH-1:0] w_quo_nxt;
   logic [WIDTH-1:0] w_q_fix;
   logic [WIDTH-1:0] w_r_fix;

   assign w_accept = i_in_valid && r_in_ready;
   assign w_take   = r_out_valid && i_out_ready;
   assign w_last   = (r_cnt == CW'(WIDTH));

   // Operand conditioning: magnitudes plus the sign bookkeeping for the final fixup.
   assign w_sgn    = SIGNED_EN && i_is_signed;
   assign w_a_neg  = w_sgn && i_a[WIDTH-1];
   assign w_b_neg  = w_sgn && i_b[WIDTH-1];
   assign w_a_abs  = w_a_neg ? -i_a : i_a;
   assign w_b_abs  = w_b_neg ? -i_b : i_b;
   assign w_min    = {1'b1, {(WIDTH-1){1'b0}}};
   assign w_ovf_in = w_sgn && (i_a == w_min) && (i_b == {WIDTH{1'b1}});

   // One restoring step, compared at WIDTH+1 bits so the shifted-out bit is kept.
   assign w_shift   = {r_rem, r_dvd[WIDTH-1]};
   assign w_ge      = (w_shift >= {1'b0, r_div});
   assign w_sub     = WIDTH'(w_shift - {1'b0, r_div});
   assign w_rem_nxt = w_ge ? w_sub : w_shift[WIDTH-1:0];
   assign w_quo_nxt = {r_dvd[WIDTH-2:0], w_ge};

   assign w_q_fix = r_dz ? {WIDTH{1'b1}} : (r_neg_q ? -r_dvd : r_dvd);
   assign w_r_fix = r_dz ? r_a : (r_neg_r ? -r_rem : r_rem);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_state_nxt = BUSY;
         BUSY:    if (w_last)   w_state_nxt = DONE;
         DONE:    if (w_take)   w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_in_ready  <= (w_state_nxt == IDLE);
         r_out_valid <= (w_state_nxt == DONE);
      end
   end

   // Datapath: load on accept, iterate in BUSY, sign fixup on the last BUSY edge.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_dvd   <= '0;
         r_div   <= '0;
         r_rem   <= '0;
         r_a     <= '0;
         r_cnt   <= '0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_dz    <= 1'b0;
         r_ovf   <= 1'b0;
         r_q     <= '0;
         r_r     <= '0;
         r_dz_o  <= 1'b0;
         r_ovf_o <= 1'b0;
      end else begin
         if (w_accept) begin
            r_dvd   <= w_a_abs;
            r_div   <= w_b_abs;
            r_rem   <= '0;
            r_a     <= i_a;
            r_cnt   <= '0;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_dz    <= (i_b == '0);
            r_ovf   <= w_ovf_in;
         end
         if (r_state == BUSY) begin
            if (!w_last) begin
               r_dvd <= w_quo_nxt;
               r_rem <= w_rem_nxt;
               r_cnt <= r_cnt + CW'(1);
            end else begin
               r_q     <= w_q_fix;
               r_r     <= w_r_fix;
               r_dz_o  <= r_dz;
               r_ovf_o <= r_ovf;
            end
         end
         if (w_take) begin
            r_dz_o  <= 1'b0;
            r_ovf_o <= 1'b0;
         end
      end
   end

   assign o_in_ready    = r_in_ready;
   assign o_out_valid   = r_out_valid;
   assign o_q           = r_q;
   assign o_r           = r_r;
   assign o_div_by_zero = r_dz_o;
   assign o_overflow    = r_ovf_o;

endmodule
